// File: rtl/jtcop_obj_dma_pkg.sv
// Shared constants for the object-table DMA: table geometry and
// the copy state machine encoding.
package jtcop_obj_dma_pkg;

   localparam int OBJ_AW    = 10;
   localparam int OBJ_WORDS = 1024;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_COPY = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Ports: clk, rst_n (clears read register only), we/waddr/wdata, raddr/rdata.
module jtframe_dual_ram
   import jtcop_obj_dma_pkg::*;
#(
   parameter int DW = 16,
   parameter int AW = OBJ_AW + 1
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:2**AW-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Only the output register is reset; array contents survive reset.
   always_ff @(posedge clk) begin
      if (!rst_n) rdata <= '0;
      else        rdata <= mem[raddr];
   end

endmodule

// File: rtl/jtcop_obj_dma.sv
// Object-table DMA with double buffer: copies CPU object RAM into the
// back bank on dma_trig and swaps banks at the start of vertical blank.
// Ports: clk, rst_n, LVBL, dma_trig, bus_req/bus_ack, ram_addr/ram_dout
// (CPU RAM side), tbl_addr/tbl_dout (draw side), busy, bank.
module jtcop_obj_dma
   import jtcop_obj_dma_pkg::*;
#(
   parameter int AW   = OBJ_AW,
   parameter int LAST = 2**AW-1
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          LVBL,
   input  logic          dma_trig,
   output logic          bus_req,
   input  logic          bus_ack,
   output logic [AW-1:0] ram_addr,
   input  logic [15:0]   ram_dout,
   input  logic [AW-1:0] tbl_addr,
   output logic [15:0]   tbl_dout,
   output logic          busy,
   output logic          bank
);

   logic [1:0]    state;
   logic          pending;
   logic          fresh;
   logic          last_iss;
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic          lvbl_l;
   logic          vb_edge;

   assign busy    = (state == ST_REQ) || (state == ST_COPY);
   assign bus_req = busy;
   assign vb_edge = !LVBL && lvbl_l;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         pending  <= 1'b0;
         fresh    <= 1'b0;
         last_iss <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         ram_addr <= '0;
         bank     <= 1'b0;
         lvbl_l   <= 1'b0;
      end else begin
         lvbl_l   <= LVBL;
         // A word issued last cycle is written now, granted or not.
         wr_valid <= 1'b0;
         if (dma_trig && state != ST_IDLE) pending <= 1'b1;
         unique case (state)
            ST_IDLE: begin
               if (dma_trig || pending) begin
                  pending <= 1'b0;
                  state   <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (bus_ack) begin
                  ram_addr <= '0;
                  last_iss <= 1'b0;
                  state    <= ST_COPY;
               end
            end
            ST_COPY: begin
               if (bus_ack && !last_iss) begin
                  wr_valid <= 1'b1;
                  wr_addr  <= ram_addr;
                  if (ram_addr == AW'(LAST)) last_iss <= 1'b1;
                  else ram_addr <= ram_addr + 1'b1;
               end
               if (last_iss && wr_valid) state <= ST_DONE;
            end
            ST_DONE: begin
               fresh <= 1'b1;
               if (pending) begin
                  pending <= 1'b0;
                  state   <= ST_REQ;
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
         // A completed table waits for a frame edge with no copy running.
         if (vb_edge && fresh && !busy) begin
            bank  <= ~bank;
            fresh <= 1'b0;
         end
      end
   end

   jtframe_dual_ram #(
      .DW(16),
      .AW(AW+1)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_valid),
      .waddr ({~bank, wr_addr}),
      .wdata (ram_dout),
      .raddr ({bank, tbl_addr}),
      .rdata (tbl_dout)
   );

endmodule
